// File: rtl/ads1675_pkg.sv
// Shared types and default timing constants for the ADS1675 acquisition sequencer.
package ads1675_pkg;

  localparam int unsigned SAMPLE_W           = 24;
  localparam int unsigned STATE_W            = 3;
  localparam int unsigned PU_WAIT_DEF        = 65536;
  localparam int unsigned SETTLE_SAMPLES_DEF = 64;
  localparam int unsigned FCNT_W_DEF         = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF    = 3'd0,
    ST_PWRUP  = 3'd1,
    ST_IDLE   = 3'd2,
    ST_START  = 3'd3,
    ST_SETTLE = 3'd4,
    ST_ALIGN  = 3'd5,
    ST_RUN    = 3'd6,
    ST_ERROR  = 3'd7
  } state_e;

  // Counter width able to hold 0..n, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/ads1675_dly_cnt.sv
// Loadable down-counter; done_c is high while the count sits at zero.
module ads1675_dly_cnt
  import ads1675_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done_c
);

  logic [W-1:0] cnt_q;

  // Load has priority; decrement stops at zero.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_c = (cnt_q == '0);

endmodule

// File: rtl/ads1675_acq_ctrl.sv
// ADS1675 acquisition sequencer: power-up, start, settle, frame alignment and
// whole-frame gating of the raw capture stream.
module ads1675_acq_ctrl
  import ads1675_pkg::*;
#(
  parameter int unsigned PU_WAIT        = PU_WAIT_DEF,
  parameter int unsigned SETTLE_SAMPLES = SETTLE_SAMPLES_DEF,
  parameter int unsigned FCNT_W         = FCNT_W_DEF
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                cmd_pd,
  input  logic                cmd_arm,
  input  logic                cmd_stop,
  input  logic [FCNT_W-1:0]   cmd_frames,
  output logic                ctrl_pd,
  output logic                ctrl_start,
  input  logic                adc_overflow,
  input  logic [SAMPLE_W-1:0] s_axis_tdata,
  input  logic                s_axis_tlast,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [SAMPLE_W-1:0] m_axis_tdata,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                busy,
  output logic                err_overflow,
  output logic [FCNT_W-1:0]   frames_done,
  output logic [STATE_W-1:0]  state_o
);

  localparam int unsigned PU_CNT_W  = cnt_w(PU_WAIT);
  localparam int unsigned SET_CNT_W = cnt_w(SETTLE_SAMPLES);
  // Counters run down to zero, so they are loaded with one less than the span.
  localparam logic [PU_CNT_W-1:0]  PU_LOAD  = PU_CNT_W'(PU_WAIT - 1);
  localparam logic [SET_CNT_W-1:0] SET_LOAD =
    SET_CNT_W'((SETTLE_SAMPLES == 0) ? 0 : SETTLE_SAMPLES - 1);

  state_e              state_q;
  state_e              state_d;
  logic                arm_take_c;
  logic                active_c;
  logic                in_beat_c;
  logic                count_hit_c;
  logic                pu_done_c;
  logic                set_done_c;
  logic [FCNT_W-1:0]   frames_tgt_q;
  logic [FCNT_W-1:0]   frames_done_q;
  logic                stop_pend_q;
  logic                err_q;
  logic                ctrl_pd_q;
  logic                ctrl_start_q;
  logic                busy_q;

  assign active_c    = (state_q == ST_START) || (state_q == ST_SETTLE) ||
                       (state_q == ST_ALIGN) || (state_q == ST_RUN);
  assign in_beat_c   = s_axis_tvalid && s_axis_tready;
  assign count_hit_c = (frames_tgt_q != '0) &&
                       (FCNT_W'(frames_done_q + FCNT_W'(1)) == frames_tgt_q);

  // Power-up hold: reloaded while powered down, counts every cycle in PWRUP.
  ads1675_dly_cnt #(.W(PU_CNT_W)) u_pu_cnt (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .load     (state_q == ST_OFF),
    .load_val (PU_LOAD),
    .en       (state_q == ST_PWRUP),
    .done_c   (pu_done_c)
  );

  // Filter settling: reloaded in START, counts accepted beats in SETTLE.
  ads1675_dly_cnt #(.W(SET_CNT_W)) u_settle_cnt (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .load     (state_q == ST_START),
    .load_val (SET_LOAD),
    .en       ((state_q == ST_SETTLE) && in_beat_c),
    .done_c   (set_done_c)
  );

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: power-down beats overflow, which beats stop/end-of-count, which beats arm.
  always_comb begin
    state_d    = state_q;
    arm_take_c = 1'b0;
    if (cmd_pd) begin
      state_d = ST_OFF;
    end else if (adc_overflow && active_c) begin
      state_d = ST_ERROR;
    end else begin
      unique case (state_q)
        ST_OFF:    state_d = ST_PWRUP;
        ST_PWRUP:  if (pu_done_c) state_d = ST_IDLE;
        ST_IDLE,
        ST_ERROR: begin
          if (cmd_arm) begin
            state_d    = ST_START;
            arm_take_c = 1'b1;
          end
        end
        ST_START:  state_d = (SETTLE_SAMPLES == 0) ? ST_ALIGN : ST_SETTLE;
        ST_SETTLE: begin
          if (cmd_stop)                     state_d = ST_IDLE;
          else if (in_beat_c && set_done_c) state_d = ST_ALIGN;
        end
        ST_ALIGN: begin
          if (cmd_stop)                       state_d = ST_IDLE;
          else if (in_beat_c && s_axis_tlast) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (in_beat_c && s_axis_tlast && (stop_pend_q || count_hit_c)) state_d = ST_IDLE;
        end
        default:   state_d = ST_OFF;
      endcase
    end
  end

  // Stream gate: pass-through only in RUN, otherwise sink and drop every beat.
  always_comb begin
    s_axis_tready = 1'b1;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = s_axis_tdata;
    m_axis_tlast  = s_axis_tlast;
    if (state_q == ST_RUN) begin
      m_axis_tvalid = s_axis_tvalid;
      s_axis_tready = m_axis_tready;
    end
  end

  // Registered controls, status and frame bookkeeping, decoded from the next state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ctrl_pd_q     <= 1'b1;
      ctrl_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      frames_tgt_q  <= '0;
      frames_done_q <= '0;
      stop_pend_q   <= 1'b0;
    end else begin
      ctrl_pd_q    <= (state_d == ST_OFF);
      ctrl_start_q <= (state_d == ST_START) || (state_d == ST_SETTLE) ||
                      (state_d == ST_ALIGN) || (state_d == ST_RUN);
      busy_q       <= !((state_d == ST_OFF) || (state_d == ST_IDLE) || (state_d == ST_ERROR));

      if (state_d == ST_ERROR) begin
        err_q <= 1'b1;
      end else if (arm_take_c) begin
        err_q <= 1'b0;
      end

      if (arm_take_c) begin
        frames_tgt_q  <= cmd_frames;
        frames_done_q <= '0;
      end else if ((state_q == ST_RUN) && in_beat_c && s_axis_tlast && (frames_done_q != '1)) begin
        frames_done_q <= frames_done_q + FCNT_W'(1);
      end

      if (state_d != ST_RUN) begin
        stop_pend_q <= 1'b0;
      end else if ((state_q == ST_RUN) && cmd_stop) begin
        stop_pend_q <= 1'b1;
      end
    end
  end

  assign ctrl_pd      = ctrl_pd_q;
  assign ctrl_start   = ctrl_start_q;
  assign busy         = busy_q;
  assign err_overflow = err_q;
  assign frames_done  = frames_done_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_ads1675_acq_ctrl.sv
// Scoreboard bench for ads1675_acq_ctrl: a random ADC-like source, a reference
// that slices the expected output frames out of the generated source stream,
// and a monitor that checks every delivered beat in order.
module tb_ads1675_acq_ctrl;
  import ads1675_pkg::*;

  localparam int unsigned PU_N      = 16;
  localparam int unsigned SETTLE_N  = 4;
  localparam int unsigned FW        = 16;
  localparam int          FRAME_LEN = 8;
  localparam int          SRC_MAX   = 256;

  typedef struct packed {
    logic [SAMPLE_W-1:0] data;
    logic                last;
  } beat_t;

  logic                aclk = 1'b0;
  logic                aresetn;
  logic                cmd_pd;
  logic                cmd_arm;
  logic                cmd_stop;
  logic [FW-1:0]       cmd_frames;
  logic                ctrl_pd;
  logic                ctrl_start;
  logic                adc_overflow;
  logic [SAMPLE_W-1:0] s_axis_tdata;
  logic                s_axis_tlast;
  logic                s_axis_tvalid;
  logic                s_axis_tready;
  logic [SAMPLE_W-1:0] m_axis_tdata;
  logic                m_axis_tlast;
  logic                m_axis_tvalid;
  logic                m_axis_tready;
  logic                busy;
  logic                err_overflow;
  logic [FW-1:0]       frames_done;
  logic [STATE_W-1:0]  state_o;

  int n_checks = 0;
  int n_fail   = 0;
  int out_cnt  = 0;
  int out_base = 0;
  int acq_id   = 0;
  int ready_mode = 0;

  logic [SAMPLE_W-1:0] src_data [SRC_MAX];
  logic                src_last [SRC_MAX];
  beat_t               exp_q [$];

  ads1675_acq_ctrl #(
    .PU_WAIT        (PU_N),
    .SETTLE_SAMPLES (SETTLE_N),
    .FCNT_W         (FW)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cmd_pd        (cmd_pd),
    .cmd_arm       (cmd_arm),
    .cmd_stop      (cmd_stop),
    .cmd_frames    (cmd_frames),
    .ctrl_pd       (ctrl_pd),
    .ctrl_start    (ctrl_start),
    .adc_overflow  (adc_overflow),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .err_overflow  (err_overflow),
    .frames_done   (frames_done),
    .state_o       (state_o)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_state(input state_e s, input int max_cyc, input string name);
    int n = 0;
    while (state_o !== s && n < max_cyc) begin
      @(negedge aclk);
      n++;
    end
    chk(name, 32'(state_o), 32'(s));
  endtask

  task automatic wait_out(input int n, input int max_cyc);
    int c = 0;
    while ((out_cnt - out_base) < n && c < max_cyc) begin
      @(negedge aclk);
      c++;
    end
    chk("out_progress", 32'((out_cnt - out_base) >= n), 32'd1);
  endtask

  // Build a fresh source stream with a random frame phase, queue the frames the
  // controller must deliver (skip the settle beats, skip through the first
  // frame end after them, then whole frames), and arm.
  task automatic run_acq(input int nf_cmd, input int nf_push);
    int p;
    int k;
    beat_t b;
    @(negedge aclk);
    p = int'($urandom_range(0, FRAME_LEN - 1));
    for (int i = 0; i < SRC_MAX; i++) begin
      src_data[i] = SAMPLE_W'($urandom);
      src_last[i] = (((p + i) % FRAME_LEN) == FRAME_LEN - 1);
    end
    k = int'(SETTLE_N);
    while (((p + k) % FRAME_LEN) != FRAME_LEN - 1) k++;
    for (int i = k + 1; i <= k + FRAME_LEN * nf_push; i++) begin
      b.data = src_data[i];
      b.last = src_last[i];
      exp_q.push_back(b);
    end
    acq_id++;
    out_base = out_cnt;
    tick;
    cmd_frames = FW'(nf_cmd);
    cmd_arm    = 1'b1;
    @(negedge aclk);
    chk("start_before_arm", 32'(ctrl_start), 32'd0);
    tick;
    cmd_arm = 1'b0;
    @(negedge aclk);
    chk("start_after_arm", 32'(ctrl_start), 32'd1);
    chk("state_start", 32'(state_o), 32'(ST_START));
    chk("frames_cleared", 32'(frames_done), 32'd0);
    chk("err_clear_on_arm", 32'(err_overflow), 32'd0);
    chk("busy_on_arm", 32'(busy), 32'd1);
  endtask

  task automatic finish_acq(input int nf, input string tag);
    wait_state(ST_IDLE, 2000, {tag, "_idle"});
    chk({tag, "_frames_done"}, 32'(frames_done), 32'(nf));
    chk({tag, "_start_low"}, 32'(ctrl_start), 32'd0);
    chk({tag, "_beat_count"}, 32'(out_cnt - out_base), 32'(FRAME_LEN * nf));
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ADC-like source: emits only after it has seen ctrl_start high, random valid gaps.
  initial begin
    int  src_idx = 0;
    int  seen_id = 0;
    logic src_en = 1'b0;
    logic acc;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    forever begin
      @(negedge aclk);
      acc = s_axis_tvalid && s_axis_tready;
      @(posedge aclk);
      #1;
      if (acc) src_idx++;
      if (acq_id != seen_id) begin
        seen_id = acq_id;
        src_idx = 0;
      end
      if (src_en && src_idx < SRC_MAX) begin
        if (acc || !s_axis_tvalid) s_axis_tvalid = ($urandom_range(0, 3) != 0);
        s_axis_tdata = src_data[src_idx];
        s_axis_tlast = src_last[src_idx];
      end else begin
        s_axis_tvalid = 1'b0;
      end
      src_en = ctrl_start;
    end
  end

  // Downstream ready pattern: held high, toggling, or random.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (ready_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = ($urandom_range(0, 1) != 0);
      endcase
    end
  end

  // Monitor: gating checks and in-order scoreboard of delivered beats.
  initial begin
    beat_t e;
    forever begin
      @(negedge aclk);
      if (aresetn === 1'b1) begin
        if (state_o == ST_RUN)
          chk("tready_mirror", 32'(s_axis_tready), 32'(m_axis_tready));
        if (state_o == ST_SETTLE || state_o == ST_ALIGN)
          chk("drop_gate", 32'({s_axis_tready, m_axis_tvalid}), 32'd2);
        if (m_axis_tvalid && m_axis_tready) begin
          chk("beat_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_data", 32'(m_axis_tdata), 32'(e.data));
            chk("out_last", 32'(m_axis_tlast), 32'(e.last));
          end
          out_cnt++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt;
    int  nf;
    logic start_seen;

    aresetn      = 1'b0;
    cmd_pd       = 1'b0;
    cmd_arm      = 1'b0;
    cmd_stop     = 1'b0;
    cmd_frames   = '0;
    adc_overflow = 1'b0;
    repeat (3) @(negedge aclk);

    // Reset values
    chk("rst_state", 32'(state_o), 32'(ST_OFF));
    chk("rst_ctrl_pd", 32'(ctrl_pd), 32'd1);
    chk("rst_ctrl_start", 32'(ctrl_start), 32'd0);
    chk("rst_err", 32'(err_overflow), 32'd0);
    chk("rst_frames", 32'(frames_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s_tready", 32'(s_axis_tready), 32'd1);
    chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);

    // Power-up sequence
    #1 aresetn = 1'b1;
    @(negedge aclk);
    chk("pwrup_entry", 32'(state_o), 32'(ST_PWRUP));
    chk("pwrup_ctrl_pd", 32'(ctrl_pd), 32'd0);
    cnt = 1;
    start_seen = ctrl_start;
    while (state_o == ST_PWRUP && cnt < 100) begin
      @(negedge aclk);
      if (ctrl_start) start_seen = 1'b1;
      if (state_o == ST_PWRUP) cnt++;
    end
    chk("pwrup_cycles", 32'(cnt), 32'(PU_N));
    chk("pwrup_to_idle", 32'(state_o), 32'(ST_IDLE));
    chk("pwrup_no_start", 32'(start_seen), 32'd0);

    // Bounded acquisition of two frames
    run_acq(2, 2);
    finish_acq(2, "bounded2");

    // Continuous mode, stop during the second output frame
    repeat (4) @(negedge aclk);
    run_acq(0, 2);
    wait_out(FRAME_LEN + 3, 1000);
    tick;
    cmd_stop = 1'b1;
    tick;
    cmd_stop = 1'b0;
    finish_acq(2, "stop");
    repeat (10) @(negedge aclk);
    chk("stop_no_trailing_beats", 32'(out_cnt - out_base), 32'(2 * FRAME_LEN));

    // Toggling downstream ready
    repeat (4) @(negedge aclk);
    ready_mode = 1;
    run_acq(3, 3);
    finish_acq(3, "toggle");
    ready_mode = 0;

    // Random frame counts with random backpressure
    for (int r = 0; r < 3; r++) begin
      repeat (4) @(negedge aclk);
      ready_mode = 2;
      nf = int'($urandom_range(1, 3));
      run_acq(nf, nf);
      finish_acq(nf, "random");
    end
    ready_mode = 0;

    // Overflow mid-RUN, then re-arm from ERROR
    repeat (4) @(negedge aclk);
    run_acq(0, 4);
    wait_out(5, 1000);
    tick;
    adc_overflow = 1'b1;
    tick;
    adc_overflow = 1'b0;
    @(negedge aclk);
    chk("ovf_state", 32'(state_o), 32'(ST_ERROR));
    chk("ovf_err", 32'(err_overflow), 32'd1);
    chk("ovf_start_low", 32'(ctrl_start), 32'd0);
    chk("ovf_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (5) @(negedge aclk);
    chk("ovf_sticky", 32'(err_overflow), 32'd1);
    chk("ovf_hold_state", 32'(state_o), 32'(ST_ERROR));
    run_acq(1, 1);
    finish_acq(1, "rearm");
    chk("rearm_err_clear", 32'(err_overflow), 32'd0);

    // Power-down and overflow on the same cycle: power-down wins
    repeat (4) @(negedge aclk);
    run_acq(0, 4);
    wait_out(3, 1000);
    tick;
    cmd_pd       = 1'b1;
    adc_overflow = 1'b1;
    tick;
    adc_overflow = 1'b0;
    @(negedge aclk);
    chk("pd_state", 32'(state_o), 32'(ST_OFF));
    chk("pd_ctrl_pd", 32'(ctrl_pd), 32'd1);
    chk("pd_err", 32'(err_overflow), 32'd0);
    chk("pd_start_low", 32'(ctrl_start), 32'd0);
    chk("pd_busy", 32'(busy), 32'd0);
    exp_q.delete();
    tick;
    cmd_pd = 1'b0;
    wait_state(ST_IDLE, 100, "pd_release_idle");
    chk("pd_release_ctrl_pd", 32'(ctrl_pd), 32'd0);

    repeat (5) @(negedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
